// File: rtl/mandel_scan_sequencer.sv
// ============================================================================
//  Module   : mandel_scan_sequencer
//  Purpose  : Raster frame scanner: launches one Mandelbrot engine run per
//             pixel and emits a colour-mapped pixel under valid/ready.
//             Optional engine watchdog: define MANDEL_SCAN_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mandel_scan_sequencer #(
    parameter int FIXED_POINT_WIDTH = 16,
    parameter int H_PIXELS          = 160,
    parameter int V_PIXELS          = 120,
    parameter int ITER_WIDTH        = 8
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             cfg_valid,
    input  logic [3*FIXED_POINT_WIDTH-1:0]   cfg_data,
    output logic                             eng_start,
    output logic [FIXED_POINT_WIDTH-1:0]     eng_c_real,
    output logic [FIXED_POINT_WIDTH-1:0]     eng_c_imag,
    input  logic                             eng_valid,
    input  logic                             eng_is_mandelbrot,
    input  logic [ITER_WIDTH-1:0]            eng_iterations,
    output logic                             pix_valid,
    input  logic                             pix_ready,
    output logic [23:0]                      pix_color,
    output logic [$clog2(H_PIXELS)-1:0]      pix_x,
    output logic [$clog2(V_PIXELS)-1:0]      pix_y,
    output logic                             pix_last,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int FPW = FIXED_POINT_WIDTH;
    localparam int XW  = $clog2(H_PIXELS);
    localparam int YW  = $clog2(V_PIXELS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_EMIT   = 2'd3;

    localparam logic [XW-1:0] c_X_LAST = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(V_PIXELS - 1);

    logic [1:0]     r_state;
    logic [FPW-1:0] r_origin_re;
    logic [FPW-1:0] r_step;
    logic [FPW-1:0] r_acc_re;
    logic [FPW-1:0] r_acc_im;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [23:0]    r_color;

    logic [7:0]     w_it;
    logic [23:0]    w_color;
    logic           w_x_last;
    logic           w_y_last;
    logic           w_timeout;

    generate
        if (ITER_WIDTH >= 8) begin : g_it_trunc
            assign w_it = eng_iterations[7:0];
        end else begin : g_it_ext
            assign w_it = {{(8 - ITER_WIDTH){1'b0}}, eng_iterations};
        end
    endgenerate

    assign w_color  = {w_it, w_it[5:0], 2'b00, ~w_it};
    assign w_x_last = (r_x == c_X_LAST);
    assign w_y_last = (r_y == c_Y_LAST);

`ifdef MANDEL_SCAN_TIMEOUT_EN
    // Watchdog limit: 2^ITER_WIDTH + 8 cycles spent in WAIT.
    localparam int              WDW         = ITER_WIDTH + 2;
    localparam logic [WDW-1:0]  c_WDOG_LAST = WDW'((1 << ITER_WIDTH) + 7);

    logic [WDW-1:0] r_wdog;
    logic           r_timeout_err;

    assign w_timeout   = (r_state == S_WAIT) && !eng_valid && (r_wdog == c_WDOG_LAST);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT) begin
                r_wdog <= r_wdog + WDW'(1);
            end
            if (r_state == S_IDLE && cfg_valid) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_origin_re <= '0;
            r_step      <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_color     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_origin_re <= cfg_data[FPW-1:0];
                        r_step      <= cfg_data[3*FPW-1:2*FPW];
                        r_acc_re    <= cfg_data[FPW-1:0];
                        r_acc_im    <= cfg_data[2*FPW-1:FPW];
                        r_x         <= '0;
                        r_y         <= '0;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_valid) begin
                        r_color <= eng_is_mandelbrot ? 24'h000000 : w_color;
                        r_state <= S_EMIT;
                    end else if (w_timeout) begin
                        r_color <= 24'hFF00FF;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (pix_ready) begin
                        if (w_x_last && w_y_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            // Row wrap rewinds real axis; imaginary axis walks downward.
                            if (w_x_last) begin
                                r_x      <= '0;
                                r_y      <= r_y + YW'(1);
                                r_acc_re <= r_origin_re;
                                r_acc_im <= r_acc_im - r_step;
                            end else begin
                                r_x      <= r_x + XW'(1);
                                r_acc_re <= r_acc_re + r_step;
                            end
                            r_state <= S_LAUNCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign eng_start  = (r_state == S_LAUNCH);
    assign eng_c_real = r_acc_re;
    assign eng_c_imag = r_acc_im;
    assign pix_valid  = (r_state == S_EMIT);
    assign pix_color  = r_color;
    assign pix_x      = r_x;
    assign pix_y      = r_y;
    assign pix_last   = pix_valid & w_x_last & w_y_last;
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mandel_scan_sequencer.sv
// ============================================================================
//  Module   : tb_mandel_scan_sequencer
//  Purpose  : Directed self-checking bench for mandel_scan_sequencer (4x2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mandel_scan_sequencer;

    localparam int FPW = 16;
    localparam int H   = 4;
    localparam int V   = 2;
    localparam int IW  = 8;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [3*FPW-1:0]  cfg_data = '0;
    logic              eng_start;
    logic [FPW-1:0]    eng_c_real;
    logic [FPW-1:0]    eng_c_imag;
    logic              eng_valid = 1'b0;
    logic              eng_is_mandelbrot = 1'b0;
    logic [IW-1:0]     eng_iterations = '0;
    logic              pix_valid;
    logic              pix_ready = 1'b0;
    logic [23:0]       pix_color;
    logic [1:0]        pix_x;
    logic [0:0]        pix_y;
    logic              pix_last;
    logic              busy;
    logic              timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    mandel_scan_sequencer #(
        .FIXED_POINT_WIDTH (FPW),
        .H_PIXELS          (H),
        .V_PIXELS          (V),
        .ITER_WIDTH        (IW)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .cfg_valid         (cfg_valid),
        .cfg_data          (cfg_data),
        .eng_start         (eng_start),
        .eng_c_real        (eng_c_real),
        .eng_c_imag        (eng_c_imag),
        .eng_valid         (eng_valid),
        .eng_is_mandelbrot (eng_is_mandelbrot),
        .eng_iterations    (eng_iterations),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_color         (pix_color),
        .pix_x             (pix_x),
        .pix_y             (pix_y),
        .pix_last          (pix_last),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset(input string t);
        chk({t, "_eng_start"}, 32'(eng_start), 32'd0);
        chk({t, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({t, "_pix_color"}, 32'(pix_color), 32'd0);
        chk({t, "_pix_x"}, 32'(pix_x), 32'd0);
        chk({t, "_pix_y"}, 32'(pix_y), 32'd0);
        chk({t, "_pix_last"}, 32'(pix_last), 32'd0);
        chk({t, "_busy"}, 32'(busy), 32'd0);
        chk({t, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({t, "_c_real"}, 32'(eng_c_real), 32'd0);
        chk({t, "_c_imag"}, 32'(eng_c_imag), 32'd0);
    endtask

    task automatic wait_start(input string t);
        int i;
        i = 0;
        while (!eng_start && i < 20) begin
            tick();
            i++;
        end
        if (!eng_start) chk({t, "_start_timeout"}, 32'd0, 32'd1);
    endtask

    // Engine answers 3 cycles after eng_start; optional stall and mid-frame cfg.
    task automatic do_pixel(input int x, input int y, input logic [15:0] re, input logic [15:0] im,
                            input logic m, input logic [7:0] it, input logic [23:0] col,
                            input int stall, input bit mid_cfg);
        string t;
        bit    last;
        t    = $sformatf("px%0d_%0d", x, y);
        last = (x == H - 1) && (y == V - 1);
        wait_start(t);
        chk({t, "_re"}, 32'(eng_c_real), 32'(re));
        chk({t, "_im"}, 32'(eng_c_imag), 32'(im));
        tick();
        if (mid_cfg) begin
            cfg_data  = {16'h0100, 16'h7000, 16'h1000};
            cfg_valid = 1'b1;
        end
        chk({t, "_c_hold"}, {eng_c_real, eng_c_imag}, {re, im});
        tick();
        cfg_valid = 1'b0;
        tick();
        eng_valid         = 1'b1;
        eng_is_mandelbrot = m;
        eng_iterations    = it;
        tick();
        eng_valid         = 1'b0;
        eng_is_mandelbrot = 1'b0;
        eng_iterations    = '0;
        chk({t, "_pix_valid"}, 32'(pix_valid), 32'd1);
        chk({t, "_color"}, 32'(pix_color), 32'(col));
        chk({t, "_xy"}, {29'd0, pix_x, pix_y}, {29'd0, 2'(x), 1'(y)});
        chk({t, "_last"}, 32'(pix_last), 32'(last));
        for (int k = 0; k < stall; k++) begin
            tick();
            chk({t, "_stall"}, {3'd0, pix_valid, pix_color, pix_x, pix_y, eng_start},
                {3'd0, 1'b1, col, 2'(x), 1'(y), 1'b0});
        end
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        if (last) begin
            chk({t, "_busy_fall"}, {30'd0, busy, pix_valid}, 32'd0);
        end else begin
            chk({t, "_next_start"}, 32'(eng_start), 32'd1);
        end
    endtask

    initial begin
        int cnt;

        nrst = 1'b0;
        repeat (3) tick();
        check_reset("reset");
        nrst = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        cfg_data  = {16'h0400, 16'h2000, 16'hC000};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("cfg_busy", 32'(busy), 32'd1);
        chk("cfg_start", 32'(eng_start), 32'd1);

        do_pixel(0, 0, 16'hC000, 16'h2000, 1'b0, 8'h05, 24'h0514FA, 0, 1'b0);
        do_pixel(1, 0, 16'hC400, 16'h2000, 1'b1, 8'h77, 24'h000000, 0, 1'b0);
        do_pixel(2, 0, 16'hC800, 16'h2000, 1'b0, 8'h80, 24'h80007F, 10, 1'b0);
        do_pixel(3, 0, 16'hCC00, 16'h2000, 1'b0, 8'hFF, 24'hFFFC00, 0, 1'b1);
        do_pixel(0, 1, 16'hC000, 16'h1C00, 1'b0, 8'h3C, 24'h3CF0C3, 0, 1'b0);
        do_pixel(1, 1, 16'hC400, 16'h1C00, 1'b0, 8'h01, 24'h0104FE, 0, 1'b0);
        do_pixel(2, 1, 16'hC800, 16'h1C00, 1'b0, 8'h00, 24'h0000FF, 0, 1'b0);
        do_pixel(3, 1, 16'hCC00, 16'h1C00, 1'b0, 8'h41, 24'h4104BE, 0, 1'b0);

        // Back-to-back frame: cfg in the first IDLE cycle after the final handshake.
        cfg_data  = {16'h0100, 16'hF000, 16'h1000};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("f2_start", 32'(eng_start), 32'd1);
        do_pixel(0, 0, 16'h1000, 16'hF000, 1'b0, 8'h05, 24'h0514FA, 0, 1'b0);
        do_pixel(1, 0, 16'h1100, 16'hF000, 1'b0, 8'h01, 24'h0104FE, 0, 1'b0);
        wait_start("f2_px2");
        chk("f2_px2_re", 32'(eng_c_real), 32'h1200);
        tick();
        nrst = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        nrst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            eng_valid = k[0];
            pix_ready = 1'b1;
            tick();
            if (eng_start || pix_valid || busy) cnt++;
        end
        eng_valid = 1'b0;
        pix_ready = 1'b0;
        chk("post_rst_quiet", 32'(cnt), 32'd0);

`ifdef MANDEL_SCAN_TIMEOUT_EN
        cfg_data  = {16'h0400, 16'h2000, 16'hC000};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_start("to");
        cnt = 0;
        while (!pix_valid && cnt < 400) begin
            tick();
            cnt++;
        end
        chk("to_cycles", 32'(cnt), 32'd265);
        chk("to_color", 32'(pix_color), 32'hFF00FF);
        chk("to_err", 32'(timeout_err), 32'd1);
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        chk("to_next_start", 32'(eng_start), 32'd1);
        chk("to_next_re", 32'(eng_c_real), 32'hC400);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mandel_scan_sequencer.md
# mandel_scan_sequencer

Frame-scan controller that sequences the Mandelbrot iteration engine. It latches a view configuration delivered by the SPI receiver and walks every pixel of an H_PIXELS×V_PIXELS frame in raster order. For each pixel it computes the complex coordinate c and launches one engine computation. It then maps the returned iteration count to a 24-bit colour and presents it downstream under a valid/ready handshake.

## Interface
- FIXED_POINT_WIDTH, 16, width of c values; format S.I.FFF… (1 sign bit, 1 integer bit, FIXED_POINT_WIDTH-2 fractional bits; 1.0 = 0x4000)
- H_PIXELS, 160, pixels per row (≥2)
- V_PIXELS, 120, rows per frame (≥2)
- ITER_WIDTH, 8, width of the engine iteration count
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  one-cycle pulse; cfg_data is valid
- cfg_data  in  3*FIXED_POINT_WIDTH  [FPW-1:0] origin_re, [2FPW-1:FPW] origin_im, [3FPW-1:2FPW] step (signed)
- eng_start  out  1  one-cycle launch pulse to the engine
- eng_c_real, eng_c_imag  out  FIXED_POINT_WIDTH  c for the current pixel; held stable from eng_start until eng_valid
- eng_valid  in  1  engine result strobe
- eng_is_mandelbrot  in  1  pixel is in the set
- eng_iterations  in  ITER_WIDTH  escape iteration count
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts the pixel
- pix_color  out  24  {R,G,B}
- pix_x  out  clog2(H_PIXELS)  pixel column
- pix_y  out  clog2(V_PIXELS)  pixel row
- pix_last  out  1  final pixel of the frame; qualified by pix_valid
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky engine-timeout flag (see Configuration)

## Operation
- FSM states: IDLE, LAUNCH, WAIT, EMIT.
- IDLE, cfg_valid=1:
  - latch origin_re, origin_im and step.
  - set acc_re=origin_re, acc_im=origin_im, x=0, y=0.
  - go to LAUNCH.
- LAUNCH: eng_start=1 for exactly this cycle; go to WAIT. eng_valid is ignored in LAUNCH.
- WAIT, eng_valid=1: register the colour and the in-set flag, then go to EMIT.
- EMIT: pix_valid=1; pix_color, pix_x, pix_y and pix_last are held stable until pix_ready=1.
- Handshake in EMIT:
  - last pixel (x=H_PIXELS-1, y=V_PIXELS-1): go to IDLE.
  - otherwise: advance the coordinates and go to LAUNCH.
- Coordinate advance:
  - x<H_PIXELS-1: x+1, acc_re+=step.
  - x=H_PIXELS-1: x=0, y+1, acc_re=origin_re, acc_im-=step.
- Coordinate arithmetic is FIXED_POINT_WIDTH two's complement and wraps silently (no saturation).
- eng_c_real = acc_re; eng_c_imag = acc_im.
- Colour mapping, with it = eng_iterations zero-extended or truncated to 8 bits:
  - eng_is_mandelbrot=1: 24'h000000.
  - otherwise: R=it, G={it[5:0],2'b00}, B=~it.
- cfg_valid outside IDLE is dropped; it does not restart or alter the frame in progress.
- pix_last = pix_valid & (x=H_PIXELS-1) & (y=V_PIXELS-1).

## Timing
- Reset values:
  - state IDLE.
  - all accumulators, counters and registered config = 0.
  - eng_start=0, pix_valid=0, pix_color=0, pix_x=0, pix_y=0, pix_last=0, busy=0, timeout_err=0.
- Reset mid-frame aborts immediately; no pixel is emitted and no eng_start is issued after nrst deasserts until a new cfg_valid arrives.
- cfg_valid at cycle N: eng_start at N+1; busy rises at N+1.
- eng_valid at cycle K (in WAIT): pix_valid at K+1.
- Handshake at cycle M: next eng_start at M+1; the new eng_c_* are valid at M+1.
- Minimum per-pixel period with an engine latency of L cycles after start: L+2 cycles (LAUNCH, L-cycle wait, EMIT with pix_ready already high).
- After the final handshake, busy=0 on the next cycle; a cfg_valid in that same cycle is accepted.
- All outputs are registered or decoded from state only; there is no combinational path from pix_ready or eng_valid to any output.

## Configuration
- MANDEL_SCAN_TIMEOUT_EN defined:
  - a watchdog counts cycles in WAIT.
  - after 2^ITER_WIDTH+8 cycles with no eng_valid, go to EMIT with pix_color=24'hFF00FF and set timeout_err (cleared only by reset or by an accepted cfg_valid).
  - the watchdog clears on entry to WAIT.
- MANDEL_SCAN_TIMEOUT_EN undefined: WAIT lasts indefinitely; timeout_err is tied to 0; no watchdog logic exists.

## Test plan
- H=4, V=2, cfg origin_re=0xC000, origin_im=0x2000, step=0x0400; engine replies 3 cycles after start -> 8 pixels, in order, with eng_c pairs (C000,2000), (C400,2000), (C800,2000), (CC00,2000), (C000,1C00)…; pix_last only on (3,1); busy falls the next cycle.
- eng_is_mandelbrot=0 with iterations=0x05 -> pix_color=0x0514FA; eng_is_mandelbrot=1 -> 0x000000.
- pix_ready held low 10 cycles in EMIT -> pix_* stable throughout; no eng_start issued until 1 cycle after pix_ready=1.
- Second cfg_valid mid-frame with a different origin -> ignored; the frame completes using the first config.
- nrst pulsed during WAIT of pixel (2,0) -> every output at its reset value; no eng_start until the next cfg_valid.
- With MANDEL_SCAN_TIMEOUT_EN: engine never responds -> pix_color=0xFF00FF after 264 WAIT cycles, timeout_err=1, and the scan continues to the next pixel.
